// File: rtl/seg7_scan_driver_if.sv
// Digit-word inputs and display-drive outputs of the 7-segment scan driver.
// The master modport is the producer of the digits; slave is the driver itself.
interface seg7_scan_driver_if;
  logic        scan_clk;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;

  modport master (
    output scan_clk, digits, dp_in, blank_lz,
    input  an, seg, dp, digit_sel
  );

  modport slave (
    input  scan_clk, digits, dp_in, blank_lz,
    output an, seg, dp, digit_sel
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment multiplexer. Runs on clkin only; scan_clk is
// edge-detected as data, and the digit word is snapshotted once per frame.
module seg7_scan_driver #(
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               i_clkin,
  input  logic               i_rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  // Active-low {g..a} pattern; blank wins over the digit value.
  function automatic logic [6:0] dec7(input logic [3:0] v, input logic blank);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b0111111;
    endcase
    return blank ? 7'b1111111 : p;
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] sel,
                                    input logic blz);
    logic z;
    case (sel)
      2'd1:    z = (d[15:4]  == 12'h000);
      2'd2:    z = (d[15:8]  == 8'h00);
      2'd3:    z = (d[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return blz & z;
  endfunction

  logic [0:0]  r_state;
  logic        r_scan_q;
  logic [1:0]  r_sel;
  logic [15:0] r_digits;
  logic [3:0]  r_dp_in;
  logic        r_blank_lz;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_tick;
  logic        w_load;
  logic [1:0]  w_sel_nxt;
  logic [15:0] w_digits_nxt;
  logic [3:0]  w_dp_in_nxt;
  logic        w_blank_lz_nxt;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg_lo;
  logic [3:0]  w_an_lo;
  logic        w_dp_lit;

  assign w_tick = bus.scan_clk & ~r_scan_q;
  assign w_load = w_tick & ((r_state == ST_IDLE) | (r_sel == 2'd3));

  // Outputs are computed from the post-tick selection and snapshot so they
  // update on the same edge that registers the tick.
  always_comb begin
    w_sel_nxt      = w_load ? 2'd0 : r_sel + 2'd1;
    w_digits_nxt   = w_load ? bus.digits   : r_digits;
    w_dp_in_nxt    = w_load ? bus.dp_in    : r_dp_in;
    w_blank_lz_nxt = w_load ? bus.blank_lz : r_blank_lz;
    w_digit        = 4'(w_digits_nxt >> {w_sel_nxt, 2'b00});
    w_seg_lo       = dec7(w_digit, lz_blank(w_digits_nxt, w_sel_nxt, w_blank_lz_nxt));
    w_an_lo        = ~(4'b0001 << w_sel_nxt);
    w_dp_lit       = w_dp_in_nxt[w_sel_nxt];
  end

  always_ff @(posedge i_clkin) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_scan_q   <= 1'b1;
      r_sel      <= 2'd0;
      r_digits   <= 16'h0000;
      r_dp_in    <= 4'h0;
      r_blank_lz <= 1'b0;
      r_an       <= AN_OFF;
      r_seg      <= SEG_OFF;
      r_dp       <= DP_OFF;
    end else begin
      r_scan_q <= bus.scan_clk;
      if (w_tick) begin
        r_state <= ST_SCAN;
        r_sel   <= w_sel_nxt;
        if (w_load) begin
          r_digits   <= bus.digits;
          r_dp_in    <= bus.dp_in;
          r_blank_lz <= bus.blank_lz;
        end
        r_an  <= AN_ACTIVE_LOW  ? w_an_lo  : ~w_an_lo;
        r_seg <= SEG_ACTIVE_LOW ? w_seg_lo : ~w_seg_lo;
        r_dp  <= SEG_ACTIVE_LOW ? ~w_dp_lit : w_dp_lit;
      end
    end
  end

  assign bus.an        = r_an;
  assign bus.seg       = r_seg;
  assign bus.dp        = r_dp;
  assign bus.digit_sel = r_sel;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed frames plus randomized scanning against a
// frame-level reference model of the display.
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .i_clkin (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] SEGTAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  // Reference model: frame state and the snapshot taken when a frame starts.
  bit          m_active;
  int          m_sel;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  bit          m_blz;

  function automatic void model_reset();
    m_active = 0;
    m_sel    = 0;
    m_digits = 16'h0;
    m_dp     = 4'h0;
    m_blz    = 0;
  endfunction

  function automatic void model_tick(logic [15:0] d, logic [3:0] p, logic b);
    if (!m_active || m_sel == 3) begin
      m_active = 1;
      m_sel    = 0;
      m_digits = d;
      m_dp     = p;
      m_blz    = b;
    end else begin
      m_sel = m_sel + 1;
    end
  endfunction

  // Expected {an, seg, dp, digit_sel} for the current model state.
  function automatic logic [13:0] model_vec();
    logic [3:0] an;
    logic [6:0] sg;
    logic [3:0] val;
    bit         blank;
    int         upper;
    if (!m_active) return {4'hF, 7'h7F, 1'b1, 2'd0};
    an    = 4'hF;
    an[m_sel] = 1'b0;
    val   = 4'((m_digits / (1 << (4 * m_sel))) % 16);
    upper = int'(m_digits) / (1 << (4 * m_sel));
    blank = m_blz && (m_sel != 0) && (upper == 0);
    sg    = blank ? 7'h7F : SEGTAB[val];
    return {an, sg, ~m_dp[m_sel], 2'(m_sel)};
  endfunction

  function automatic logic [13:0] got_vec();
    return {bus.an, bus.seg, bus.dp, bus.digit_sel};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.scan_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One rising scan_clk edge; returns sampled #1 after the registering edge.
  task automatic pulse(input int low_cycles);
    @(negedge clk);
    bus.scan_clk = 1'b0;
    repeat (low_cycles) @(negedge clk);
    bus.scan_clk = 1'b1;
    model_tick(bus.digits, bus.dp_in, bus.blank_lz);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    @(negedge clk);
    rst_n = 1'b0;
    bus.scan_clk = 1'b1;
    bus.digits = 16'h1234;
    bus.dp_in = 4'hF;
    bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      got = got_vec();
      n_cmp++;
      if (got !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
        n_fail++;
        $display("FAIL reset_dark cyc=%0d got=%h exp=%h", i, got, {4'hF, 7'h7F, 1'b1, 2'd0});
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_exp [5]  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    logic [6:0] seg_exp [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
    logic [13:0] exp;
    apply_reset();
    bus.digits = 16'h1234;
    bus.dp_in = 4'h0;
    bus.blank_lz = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse(2);
      exp = {an_exp[k], seg_exp[k], 1'b1, 2'(k % 4)};
      n_cmp++;
      if (got_vec() !== exp) begin
        n_fail++;
        $display("FAIL scan step=%0d got=%h exp=%h", k, got_vec(), exp);
      end
      // falling edge and a long high phase must not move the display
      repeat (3) @(negedge clk);
      bus.scan_clk = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (got_vec() !== exp) begin
        n_fail++;
        $display("FAIL scan_hold step=%0d got=%h exp=%h", k, got_vec(), exp);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] seg_exp [3] = '{7'h24, 7'h79, 7'h00};
    apply_reset();
    bus.digits = 16'h1234;
    bus.dp_in = 4'h0;
    bus.blank_lz = 1'b0;
    pulse(1);
    pulse(1);
    bus.digits = 16'h5678;
    for (int k = 0; k < 3; k++) begin
      pulse(1);
      n_cmp++;
      if (bus.seg !== seg_exp[k] || got_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL snapshot step=%0d got=%h exp=%h seg_exp=%h", k, got_vec(), model_vec(), seg_exp[k]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] blz1 [4] = '{7'h40, 7'h78, 7'h7F, 7'h7F};
    logic [6:0] blz0 [4] = '{7'h40, 7'h78, 7'h40, 7'h40};
    logic [6:0] e;
    for (int b = 1; b >= 0; b--) begin
      apply_reset();
      bus.digits = 16'h0070;
      bus.dp_in = 4'h0;
      bus.blank_lz = 1'(b);
      for (int k = 0; k < 4; k++) begin
        pulse(1);
        e = (b == 1) ? blz1[k] : blz0[k];
        n_cmp++;
        if (bus.seg !== e || bus.an !== ~(4'b0001 << k)) begin
          n_fail++;
          $display("FAIL blank blz=%0d sel=%0d got seg=%h an=%h exp seg=%h", b, k, bus.seg, bus.an, e);
        end
      end
    end
  endtask

  task automatic test_dash_dp();
    logic [6:0] seg_exp [4] = '{7'h40, 7'h3F, 7'h7F, 7'h7F};
    logic       dp_exp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    apply_reset();
    bus.digits = 16'h00A0;
    bus.dp_in = 4'b0010;
    bus.blank_lz = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pulse(1);
      n_cmp++;
      if (bus.seg !== seg_exp[k] || bus.dp !== dp_exp[k]) begin
        n_fail++;
        $display("FAIL dash_dp sel=%0d got seg=%h dp=%b exp seg=%h dp=%b", k, bus.seg, bus.dp, seg_exp[k], dp_exp[k]);
      end
    end
  endtask

  task automatic test_midrun_reset();
    apply_reset();
    bus.digits = 16'h4321;
    bus.dp_in = 4'h0;
    bus.blank_lz = 1'b0;
    repeat (3) pulse(1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (got_vec() !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL midrun_dark got=%h exp=%h", got_vec(), {4'hF, 7'h7F, 1'b1, 2'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (got_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL midrun_no_tick got=%h exp=%h", got_vec(), model_vec());
    end
    bus.digits = 16'h9876;
    pulse(2);
    n_cmp++;
    if (got_vec() !== {4'hE, 7'h02, 1'b1, 2'd0} || got_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL midrun_restart got=%h exp=%h", got_vec(), {4'hE, 7'h02, 1'b1, 2'd0});
    end
    // reset asserted on the very edge that would register a tick
    @(negedge clk);
    bus.scan_clk = 1'b0;
    @(negedge clk);
    bus.scan_clk = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (got_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_vs_tick got=%h exp=%h", got_vec(), model_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] d;
    apply_reset();
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        d = 16'($urandom);
        for (int n = 3; n >= 1; n--)
          if ($urandom_range(0, 1) == 1) d[4*n +: 4] = 4'h0;
          else break;
        bus.digits   = d;
        bus.dp_in    = 4'($urandom);
        bus.blank_lz = 1'($urandom);
      end
      pulse($urandom_range(1, 3));
      n_cmp++;
      if (got_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random it=%0d got=%h exp=%h", it, got_vec(), model_vec());
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ((it % 5) == 0) begin
        n_cmp++;
        if (got_vec() !== model_vec()) begin
          n_fail++;
          $display("FAIL random_hold it=%0d got=%h exp=%h", it, got_vec(), model_vec());
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.scan_clk = 1'b1;
    bus.digits = 16'h0;
    bus.dp_in = 4'h0;
    bus.blank_lz = 1'b0;
    model_reset();
    test_reset();
    test_scan();
    test_snapshot();
    test_blanking();
    test_dash_dp();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
